bus_server: RTL and testbench
=============================

// Module: bus_server
// PURPOSE
//  Responder end of the arbitrated client bus. Sits behind the arbiter and serves the
//  granted client's rq/ack transaction. Samples address/wr_ni/dataW, performs a read or
//  write on a local word store after a fixed access latency, and answers with a one-cycle ack.
//  Owns one address window; accesses outside it are acknowledged and flagged via err.
// PARAMETERS
//  DATA_WIDTH           8  data bus width (dataW, dataR, stored words)
//  ADDR_WIDTH           4  address bus width
//  ADDR_SPACE_BEGINNING 0  first address owned by this server
//  ADDR_SPACE_END       3  last address owned (inclusive); depth = END-BEGINNING+1
//  ACCESS_LATENCY       2  edges from the rq-sampling edge to the ack-raising edge; legal >= 1
// PORTS
//  clk      in   1           clock, rising edge
//  reset    in   1           synchronous, active-low reset (0 = reset)
//  address  in   ADDR_WIDTH  client address
//  rq       in   1           request from the granted client, held until ack
//  ack      out  1           one-cycle completion pulse
//  wr_ni    in   1           1 = read, 0 = write
//  dataW    in   DATA_WIDTH  write data
//  dataR    out  DATA_WIDTH  read data, valid in the ack cycle, held until the next read ack
//  err      out  1           pulses with ack when the address is out of window
// BEHAVIOUR
//  Reset (reset=0 at edge): state IDLE, ack=0, err=0, dataR=0, latency counter=0, all words=0.
//   Reset takes effect at the edge regardless of state; an in-flight access is dropped, no ack.
//  FSM states are IDLE, WAIT, ACK and RELEASE.
//   IDLE: an edge with rq=1 latches address, wr_ni and dataW, loads cnt=ACCESS_LATENCY-1,
//    goes to WAIT, or goes to ACK directly if ACCESS_LATENCY=1.
//   WAIT: cnt decrements each edge. At the edge where cnt=1 it goes to ACK.
//   ACK: ack=1 for exactly one cycle, then RELEASE.
//   RELEASE: stays while rq=1. The first edge with rq=0 returns to IDLE.
//    A new request is therefore seen no earlier than the edge after rq is seen low.
//  Access commit happens at the edge that enters ACK and uses only the latched fields.
//   In window (BEGINNING <= addr <= END): write stores dataW at index addr-BEGINNING.
//    Read loads dataR from that index. err=0.
//   Out of window: writes are discarded; reads load dataR = all ones; err=1 alongside ack.
//   Writes leave dataR unchanged.
//  rq dropping in WAIT does not abort. The access completes, ack still pulses,
//   and RELEASE exits on the next edge.
//  Input changes after the latch edge (address, wr_ni, dataW) have no effect on the current access.
//  Index arithmetic is ADDR_WIDTH-bit unsigned. The window compare is done before subtraction,
//   so no wrap-around aliasing occurs.
//  Latency: with rq high at edge E0 in IDLE, ack is high from edge E0+ACCESS_LATENCY
//   to E0+ACCESS_LATENCY+1.
// STRUCTURE
//  Shared package bus_pkg holds BUS_READ=1'b1 and BUS_WRITE=1'b0 (wr_ni encoding)
//   and the server state encoding localparams.
//  Sub-module bus_server_mem: DEPTH x DATA_WIDTH register array with sync write,
//   sync read, sync active-low clear.
//  The top level holds the FSM, latency counter, request latches and window decode.
// TESTING
//  1 Write then read: write 0x5A to addr 2, then read addr 2 -> dataR=0x5A in the read ack cycle, err=0.
//  2 Latency: rq rises at E0 with ACCESS_LATENCY=2 -> ack high only between E0+2 and E0+3.
//    Repeat with ACCESS_LATENCY=1.
//  3 Out of window: write 0x11 to addr 7, then read addr 7 -> dataR=0xFF, err=1 with each ack.
//    Words 0-3 unchanged.
//  4 Hold: rq held high 10 cycles after ack -> exactly one ack. A second ack comes only
//    after rq is low at one edge and high again.
//  5 Early drop and latch: rq high one cycle, address switched 2->3 in WAIT
//    -> ack still pulses and the access targets addr 2.
//  6 Reset mid-op: reset=0 during WAIT of a write 0x77 to addr 1 -> no ack, ack=0 next cycle,
//    later read of addr 1 returns 0x00.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared client-bus definitions: wr_ni encoding and server FSM state encoding.
package bus_pkg;

   localparam logic BUS_READ  = 1'b1;
   localparam logic BUS_WRITE = 1'b0;

   localparam logic [1:0] SRV_IDLE    = 2'd0;
   localparam logic [1:0] SRV_WAIT    = 2'd1;
   localparam logic [1:0] SRV_ACK     = 2'd2;
   localparam logic [1:0] SRV_RELEASE = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = SRV_IDLE,
      WAIT    = SRV_WAIT,
      ACK     = SRV_ACK,
      RELEASE = SRV_RELEASE
   } srv_state_t;

endpackage

// File: rtl/bus_server_if.sv
// Client bus between the granted client (master) and a bus server (slave).
interface bus_server_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0] address;
   logic                  rq;
   logic                  ack;
   logic                  wr_ni;
   logic [DATA_WIDTH-1:0] dataW;
   logic [DATA_WIDTH-1:0] dataR;
   logic                  err;

   modport master (output address, rq, wr_ni, dataW, input ack, dataR, err);
   modport slave  (input address, rq, wr_ni, dataW, output ack, dataR, err);
endinterface

// File: rtl/bus_server_mem.sv
// DEPTH x DATA_WIDTH word store: sync write, registered read, sync active-low clear.
module bus_server_mem #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  i_clr_n,
   input  logic                  i_wr_en,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [DATA_WIDTH-1:0] o_rdata
);
   logic [DATA_WIDTH-1:0] r_words [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [DATA_WIDTH-1:0] w_rd_word;

   // Full-width compare per entry keeps the index free of truncation
   always_comb begin
      w_rd_word = '0;
      for (int i = 0; i < DEPTH; i++)
         if (i_addr == ADDR_WIDTH'(i)) w_rd_word = r_words[i];
   end

   always_ff @(posedge clk) begin
      if (!i_clr_n) begin
         for (int i = 0; i < DEPTH; i++) r_words[i] <= '0;
         r_rdata <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (i_wr_en && i_addr == ADDR_WIDTH'(i)) r_words[i] <= i_wdata;
         if (i_rd_en) r_rdata <= w_rd_word;
      end
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/bus_server.sv
// Responder on the arbitrated client bus: latches a request, waits the access
// latency, commits to the local word store and answers with a one-cycle ack.
//
// state   | meaning
// IDLE    | waiting for rq; latches address/wr_ni/dataW on rq
// WAIT    | counting down the access latency
// ACK     | access committed on entry; raises ack for the next cycle
// RELEASE | ack cycle and beyond; waits for rq to be seen low
module bus_server
   import bus_pkg::*;
#(
   parameter int DATA_WIDTH           = 8,
   parameter int ADDR_WIDTH           = 4,
   parameter int ADDR_SPACE_BEGINNING = 0,
   parameter int ADDR_SPACE_END       = 3,
   parameter int ACCESS_LATENCY       = 2
) (
   input  logic         clk,
   input  logic         reset,
   bus_server_if.slave  bus
);
   localparam int DEPTH = ADDR_SPACE_END - ADDR_SPACE_BEGINNING + 1;
   localparam int CNT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY + 1) : 1;

   srv_state_t            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_wr_ni;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_ack;
   logic                  r_err;
   logic                  r_err_pend;
   logic                  r_oow_rd;

   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  w_wr_ni;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic                  w_in_win;
   logic                  w_commit;
   logic [DATA_WIDTH-1:0] w_mem_rdata;

   // With single-cycle latency the commit edge is also the latch edge
   assign w_addr   = (r_state == IDLE) ? bus.address : r_addr;
   assign w_wr_ni  = (r_state == IDLE) ? bus.wr_ni   : r_wr_ni;
   assign w_wdata  = (r_state == IDLE) ? bus.dataW   : r_wdata;
   assign w_in_win = (int'(w_addr) >= ADDR_SPACE_BEGINNING) &&
                     (int'(w_addr) <= ADDR_SPACE_END);
   assign w_idx    = w_addr - ADDR_WIDTH'(ADDR_SPACE_BEGINNING);
   assign w_commit = ((r_state == IDLE) && bus.rq && (ACCESS_LATENCY == 1)) ||
                     ((r_state == WAIT) && (r_cnt == CNT_W'(1)));

   bus_server_mem #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .i_clr_n (reset),
      .i_wr_en (w_commit && (w_wr_ni == BUS_WRITE) && w_in_win),
      .i_rd_en (w_commit && (w_wr_ni == BUS_READ) && w_in_win),
      .i_addr  (w_idx),
      .i_wdata (w_wdata),
      .o_rdata (w_mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_wr_ni    <= BUS_READ;
         r_wdata    <= '0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_err_pend <= 1'b0;
         r_oow_rd   <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         if (w_commit) begin
            r_err_pend <= !w_in_win;
            if (w_wr_ni == BUS_READ) r_oow_rd <= !w_in_win;
         end
         case (r_state)
            IDLE: if (bus.rq) begin
               r_addr  <= bus.address;
               r_wr_ni <= bus.wr_ni;
               r_wdata <= bus.dataW;
               r_cnt   <= CNT_W'(ACCESS_LATENCY - 1);
               r_state <= (ACCESS_LATENCY == 1) ? ACK : WAIT;
            end
            WAIT: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) r_state <= ACK;
            end
            ACK: begin
               r_ack   <= 1'b1;
               r_err   <= r_err_pend;
               r_state <= RELEASE;
            end
            RELEASE: if (!bus.rq) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.ack   = r_ack;
   assign bus.err   = r_err;
   assign bus.dataR = r_oow_rd ? '1 : w_mem_rdata;
endmodule

// File: tb/tb_bus_server.sv
// Directed bench for bus_server: latency-2 instance for function, latency-1 instance for timing.
module tb_bus_server;
   logic clk = 1'b0;
   logic reset;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   bus_server_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_a ();
   bus_server_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_b ();

   bus_server #(.ACCESS_LATENCY(2)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   bus_server #(.ACCESS_LATENCY(1)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Edges until ack is seen high, bounded
   task automatic wait_ack_a(output int k);
      k = 0;
      do begin
         step();
         k++;
      end while (!bus_a.ack && k < 20);
   endtask

   task automatic access_a(input string tag, input logic [3:0] a, input logic wr,
                           input logic [7:0] d, output logic [7:0] rd, output logic er);
      int k;
      bus_a.address = a;
      bus_a.wr_ni   = wr;
      bus_a.dataW   = d;
      bus_a.rq      = 1'b1;
      wait_ack_a(k);
      chk({tag, "_lat"}, k, 3);
      rd = bus_a.dataR;
      er = bus_a.err;
      bus_a.rq      = 1'b0;
      bus_a.address = 4'hC;
      bus_a.dataW   = 8'hEE;
      step();
      chk({tag, "_ackpulse"}, bus_a.ack, 1'b0);
   endtask

   logic [7:0] rd;
   logic       er;
   int         k;
   int         n_ack;

   initial begin
      reset = 1'b0;
      bus_a.rq = 1'b0; bus_a.address = '0; bus_a.wr_ni = 1'b1; bus_a.dataW = '0;
      bus_b.rq = 1'b0; bus_b.address = '0; bus_b.wr_ni = 1'b1; bus_b.dataW = '0;
      step(); step();
      chk("rst_ack", bus_a.ack, 1'b0);
      chk("rst_err", bus_a.err, 1'b0);
      chk("rst_dataR", bus_a.dataR, 8'h00);
      reset = 1'b1;
      step();

      // write then read
      access_a("wr2", 4'd2, 1'b0, 8'h5A, rd, er);
      chk("wr2_err", er, 1'b0);
      chk("wr2_dataR", rd, 8'h00);
      access_a("rd2", 4'd2, 1'b1, 8'h00, rd, er);
      chk("rd2_data", rd, 8'h5A);
      chk("rd2_err", er, 1'b0);

      // out of window
      access_a("wr7", 4'd7, 1'b0, 8'h11, rd, er);
      chk("wr7_err", er, 1'b1);
      chk("wr7_dataR", rd, 8'h5A);
      access_a("rd7", 4'd7, 1'b1, 8'h00, rd, er);
      chk("rd7_data", rd, 8'hFF);
      chk("rd7_err", er, 1'b1);
      access_a("wr1", 4'd1, 1'b0, 8'h33, rd, er);
      chk("wr1_dataR_held", rd, 8'hFF);
      chk("wr1_err", er, 1'b0);
      access_a("rd0", 4'd0, 1'b1, 8'h00, rd, er);
      chk("rd0_data", rd, 8'h00);
      access_a("rd1", 4'd1, 1'b1, 8'h00, rd, er);
      chk("rd1_data", rd, 8'h33);
      access_a("rd3", 4'd3, 1'b1, 8'h00, rd, er);
      chk("rd3_data", rd, 8'h00);
      chk("rd3_err", er, 1'b0);
      access_a("rd4", 4'd4, 1'b1, 8'h00, rd, er);
      chk("rd4_data", rd, 8'hFF);
      chk("rd4_err", er, 1'b1);
      access_a("rd2b", 4'd2, 1'b1, 8'h00, rd, er);
      chk("rd2b_data", rd, 8'h5A);

      // latency 1 instance
      bus_b.address = 4'd3; bus_b.wr_ni = 1'b1; bus_b.rq = 1'b1;
      k = 0;
      do begin
         step();
         k++;
      end while (!bus_b.ack && k < 20);
      chk("b_lat", k, 2);
      chk("b_err", bus_b.err, 1'b0);
      bus_b.rq = 1'b0;
      step();
      chk("b_ackpulse", bus_b.ack, 1'b0);

      // hold rq after ack
      bus_a.address = 4'd2; bus_a.wr_ni = 1'b1; bus_a.rq = 1'b1;
      wait_ack_a(k);
      chk("hold_lat", k, 3);
      n_ack = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus_a.ack) n_ack++;
      end
      chk("hold_no_reack", n_ack, 0);
      bus_a.rq = 1'b0;
      step();
      bus_a.rq = 1'b1;
      wait_ack_a(k);
      chk("hold_second_lat", k, 3);
      bus_a.rq = 1'b0;
      step();
      chk("hold_ackpulse", bus_a.ack, 1'b0);

      // early drop; fields changed after latch edge
      bus_a.address = 4'd2; bus_a.wr_ni = 1'b0; bus_a.dataW = 8'h9C; bus_a.rq = 1'b1;
      step();
      bus_a.rq = 1'b0; bus_a.address = 4'd3; bus_a.wr_ni = 1'b1; bus_a.dataW = 8'h00;
      wait_ack_a(k);
      chk("drop_lat", k, 2);
      step();
      chk("drop_ackpulse", bus_a.ack, 1'b0);
      access_a("drop_rd2", 4'd2, 1'b1, 8'h00, rd, er);
      chk("drop_rd2_data", rd, 8'h9C);
      access_a("drop_rd3", 4'd3, 1'b1, 8'h00, rd, er);
      chk("drop_rd3_data", rd, 8'h00);

      // reset during WAIT
      bus_a.address = 4'd1; bus_a.wr_ni = 1'b0; bus_a.dataW = 8'h77; bus_a.rq = 1'b1;
      step();
      reset = 1'b0;
      bus_a.rq = 1'b0;
      step();
      chk("rstmid_ack0", bus_a.ack, 1'b0);
      chk("rstmid_dataR", bus_a.dataR, 8'h00);
      reset = 1'b1;
      step();
      chk("rstmid_ack1", bus_a.ack, 1'b0);
      step();
      chk("rstmid_ack2", bus_a.ack, 1'b0);
      access_a("rstmid_rd1", 4'd1, 1'b1, 8'h00, rd, er);
      chk("rstmid_rd1_data", rd, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
